sonic_echo_emu: RTL and testbench
=================================

Name: sonic_echo_emu

Overview:
- Emulates an HC-SR04-style ultrasonic ranging sensor, i.e. the sensor end of the trig/echo protocol.
- Watches the trig line and qualifies the trigger pulse width.
- After the acoustic-burst delay, drives echo high for a time proportional to a programmed distance: 58 us per cm.
- Used on-board for hardware-in-loop testing of the ranging front end, and in simulation as the sensor model; runs on the 50 MHz system clock.

Parameters:
- TICKS_PER_US, 50, clock cycles per microsecond.
- US_PER_CM, 58, echo microseconds per centimetre.
- MIN_TRIG_US, 2, minimum accepted trig high width.
- BURST_US, 200, delay from trig fall to echo rise.
- MAX_CM, 400, largest in-range distance.
- TIMEOUT_US, 38000, echo width for no-target or out-of-range.
- RECOVER_US, 1000, dead time after echo falls before the next trigger is accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- trig  in  1  asynchronous trigger from the ranging master.
- distance_cm  in  9  programmed target distance; 0 means no target.
- echo  out  1  registered echo pulse.
- busy  out  1  high in every state except IDLE.
- short_trig_err  out  1  one-cycle pulse when a trigger is rejected as too short.
- trig_count  out  16  accepted triggers, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE.
  - echo=0, busy=0, short_trig_err=0, trig_count=0.
  - All counters and the latched distance are cleared.
  - Synchronizer flops are set to 1, so a trig held high through reset is not an edge.
  - Reset mid-operation aborts immediately: echo is low after that edge.
- trig input path:
  - Passes through a 2-flop synchronizer, giving trig_s.
  - Edges are detected against a delayed copy, trig_d.
  - Rise: trig_s=1 and trig_d=0. Fall: trig_s=0 and trig_d=1.
- Derived constants, in cycles:
  - MINC = MIN_TRIG_US*TICKS_PER_US.
  - BURSTC = BURST_US*TICKS_PER_US.
  - RECC = RECOVER_US*TICKS_PER_US.
  - TOC = TIMEOUT_US*TICKS_PER_US.
- Echo width W, computed and latched at trigger acceptance:
  - If distance_cm is 1..MAX_CM: W = distance_cm*US_PER_CM*TICKS_PER_US.
  - Otherwise (0 or above MAX_CM): W = TOC.
  - All timing counters are 22 bits wide; the defaults need at most 1,900,000.
- FSM:
  - IDLE:
    - On rise: go to TRIG and clear the width counter.
    - A fall without a preceding rise is ignored.
  - TRIG:
    - Width counter increments each cycle while trig_s=1 and saturates at MINC.
    - On fall with count >= MINC: latch W, increment trig_count, go to BURST.
    - On fall with count < MINC: pulse short_trig_err for 1 cycle, go to IDLE.
  - BURST:
    - Counts BURSTC cycles, then goes to ECHO and sets echo=1.
    - Echo rise occurs exactly BURSTC cycles after the fall-detect edge.
  - ECHO:
    - echo stays high for exactly W cycles, then clears.
    - Goes to RECOVER.
  - RECOVER:
    - Counts RECC cycles, then goes to IDLE.
- Ignored inputs:
  - trig activity in BURST, ECHO and RECOVER has no effect.
  - distance_cm changes after acceptance do not affect the current echo.
- busy = (state != IDLE), registered.
- trig_count does not wrap.

Optional Feature:
- Macro: SONIC_EMU_JITTER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted trigger.
  - Its low 4 bits J (0..15) add J*TICKS_PER_US cycles to W for in-range distances only. TOC is never jittered.
- When undefined:
  - No LFSR logic exists.
  - W is exact as specified above.

Test Plan:
- Nominal range:
  - Stimulus: distance_cm=10, trig high 500 cycles.
  - Response: trig_count=1; echo rises 10000 cycles after fall detect; echo high exactly 29000 cycles; busy drops 50000 cycles after echo falls.
- Short trigger:
  - Stimulus: trig high 50 cycles.
  - Response: short_trig_err high exactly 1 cycle; echo stays 0; trig_count unchanged; back in IDLE.
- No target:
  - Stimulus: distance_cm=0 (repeat with 450), valid trig.
  - Response: echo high exactly 1,900,000 cycles in both cases.
- Ignore while busy:
  - Stimulus: distance_cm=5, valid trig; during ECHO pulse trig again and change distance_cm to 100.
  - Response: echo width stays 14500 cycles; trig_count=1.
  - Follow-up: a trig after RECOVER yields a 290000-cycle echo.
- Reset behaviour:
  - Stimulus: rst_n low for 1 cycle mid-ECHO.
  - Response: echo=0 and busy=0 on the next edge; trig_count=0.
  - Stimulus: trig held high across reset release, then falls.
  - Response: no echo.
- Saturation:
  - Stimulus: force trig_count to 16'hFFFE, then two valid triggers.
  - Response: trig_count reads 16'hFFFF and holds.

Source files
------------

// File: rtl/sonic_echo_emu.sv
// HC-SR04 style sensor model: qualifies trig, waits out the burst delay, then drives echo for distance*US_PER_CM us.
// Optional echo-width jitter is enabled by defining SONIC_EMU_JITTER_EN.
module sonic_echo_emu #(
  parameter int TICKS_PER_US = 50,
  parameter int US_PER_CM    = 58,
  parameter int MIN_TRIG_US  = 2,
  parameter int BURST_US     = 200,
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_US   = 38000,
  parameter int RECOVER_US   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig_err,
  output logic [15:0] trig_count
);

  localparam logic [21:0] MINC       = 22'(MIN_TRIG_US * TICKS_PER_US);
  localparam logic [21:0] BURSTC     = 22'(BURST_US * TICKS_PER_US);
  localparam logic [21:0] RECC       = 22'(RECOVER_US * TICKS_PER_US);
  localparam logic [21:0] TOC        = 22'(TIMEOUT_US * TICKS_PER_US);
  localparam logic [21:0] CYC_PER_CM = 22'(US_PER_CM * TICKS_PER_US);
  localparam logic [8:0]  MAX_D      = 9'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_BURST,
    S_ECHO,
    S_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic        meta_q, meta_d;
  logic        trig_s_q, trig_s_d;
  logic        trig_dly_q, trig_dly_d;
  logic [21:0] cnt_q, cnt_d;
  logic [21:0] w_q, w_d;
  logic [15:0] trig_count_q, trig_count_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        short_trig_err_q, short_trig_err_d;

  logic        rise, fall;
  logic        in_range;
  logic [21:0] w_calc;

  assign rise = trig_s_q & ~trig_dly_q;
  assign fall = ~trig_s_q & trig_dly_q;
  assign in_range = (distance_cm != 9'd0) && (distance_cm <= MAX_D);

`ifdef SONIC_EMU_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;
  logic [21:0] jitter;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign jitter  = 22'(lfsr_q[3:0]) * 22'(TICKS_PER_US);
  // Timeout width stays exact; only real targets get jittered.
  assign w_calc  = in_range ? (22'(distance_cm) * CYC_PER_CM + jitter) : TOC;
`else
  assign w_calc  = in_range ? (22'(distance_cm) * CYC_PER_CM) : TOC;
`endif

  always_comb begin
    meta_d     = trig;
    trig_s_d   = meta_q;
    trig_dly_d = trig_s_q;
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    w_d              = w_q;
    trig_count_d     = trig_count_q;
    short_trig_err_d = 1'b0;
`ifdef SONIC_EMU_JITTER_EN
    lfsr_d           = lfsr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_TRIG;
          cnt_d   = '0;
        end
      end

      S_TRIG: begin
        if (fall) begin
          cnt_d = '0;
          if (cnt_q >= MINC) begin
            w_d          = w_calc;
            trig_count_d = (trig_count_q == 16'hFFFF) ? trig_count_q : trig_count_q + 16'd1;
`ifdef SONIC_EMU_JITTER_EN
            lfsr_d       = {lfsr_q[14:0], lfsr_fb};
`endif
            state_d      = S_BURST;
          end else begin
            short_trig_err_d = 1'b1;
            state_d          = S_IDLE;
          end
        end else if (trig_s_q && (cnt_q < MINC)) begin
          cnt_d = cnt_q + 22'd1;
        end
      end

      // Count resets on each phase change, so each phase lasts exactly its limit.
      S_BURST: begin
        if (cnt_q >= BURSTC - 22'd1) begin
          state_d = S_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end

      S_ECHO: begin
        if (cnt_q >= w_q - 22'd1) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end

      S_RECOVER: begin
        if (cnt_q >= RECC - 22'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    echo_d = (state_d == S_ECHO);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      meta_q           <= 1'b1;
      trig_s_q         <= 1'b1;
      trig_dly_q       <= 1'b1;
      cnt_q            <= '0;
      w_q              <= '0;
      trig_count_q     <= '0;
      echo_q           <= 1'b0;
      busy_q           <= 1'b0;
      short_trig_err_q <= 1'b0;
`ifdef SONIC_EMU_JITTER_EN
      lfsr_q           <= 16'hACE1;
`endif
    end else begin
      state_q          <= state_d;
      meta_q           <= meta_d;
      trig_s_q         <= trig_s_d;
      trig_dly_q       <= trig_dly_d;
      cnt_q            <= cnt_d;
      w_q              <= w_d;
      trig_count_q     <= trig_count_d;
      echo_q           <= echo_d;
      busy_q           <= busy_d;
      short_trig_err_q <= short_trig_err_d;
`ifdef SONIC_EMU_JITTER_EN
      lfsr_q           <= lfsr_d;
`endif
    end
  end

  assign echo           = echo_q;
  assign busy           = busy_q;
  assign short_trig_err = short_trig_err_q;
  assign trig_count     = trig_count_q;

endmodule

// File: tb/tb_sonic_echo_emu.sv
// Bench for sonic_echo_emu with scaled-down timing parameters so every scenario stays short.
module tb_sonic_echo_emu;

  localparam int T     = 2;
  localparam int UPC   = 3;
  localparam int MINU  = 4;
  localparam int BU    = 10;
  localparam int MAXC  = 100;
  localparam int TOU   = 400;
  localparam int RU    = 15;
  localparam int BURSTC = BU * T;
  localparam int RECC   = RU * T;
  localparam int TOC    = TOU * T;
  localparam int RISE_LAT = BURSTC + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [8:0]  distance_cm = '0;
  logic        echo, busy, short_trig_err;
  logic [15:0] trig_count;

  int errs = 0;
  int checks = 0;
  int exp_count = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  sonic_echo_emu #(
    .TICKS_PER_US(T), .US_PER_CM(UPC), .MIN_TRIG_US(MINU), .BURST_US(BU),
    .MAX_CM(MAXC), .TIMEOUT_US(TOU), .RECOVER_US(RU)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .short_trig_err(short_trig_err), .trig_count(trig_count)
  );

  function automatic int model_width(input int d);
    int w;
    if (d >= 1 && d <= MAXC) begin
      w = d * UPC * T;
`ifdef SONIC_EMU_JITTER_EN
      w = w + int'(m_lfsr[3:0]) * T;
`endif
    end else begin
      w = TOC;
    end
    return w;
  endfunction

  task automatic model_accept();
    if (exp_count < 65535) exp_count = exp_count + 1;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic model_reset();
    exp_count = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic pulse_trig(input int h);
    @(negedge clk);
    trig = 1'b1;
    repeat (h) @(negedge clk);
    trig = 1'b0;
  endtask

  // Negedges from trig drop to echo rise, echo high negedges, negedges from echo fall to busy drop.
  task automatic measure(output int rise, output int width, output int rec);
    rise = 0; width = 0; rec = 0;
    while (!echo && rise < 2000) begin @(negedge clk); rise++; end
    if (!echo) begin rise = -1; width = -1; rec = -1; return; end
    width = 1;
    while (width < 5000) begin
      @(negedge clk);
      if (echo) width++; else break;
    end
    while (busy && rec < 5000) begin @(negedge clk); rec++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (echo !== 1'b0) begin errs++; $display("FAIL reset_echo got=%b want=0", echo); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (short_trig_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b want=0", short_trig_err); end
    checks++; if (trig_count !== 16'h0) begin errs++; $display("FAIL reset_count got=%h want=0", trig_count); end
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nominal();
    int r, w, rc, ew;
    distance_cm = 9'd10;
    ew = model_width(10);
    model_accept();
    pulse_trig(20);
    measure(r, w, rc);
    checks++; if (r != RISE_LAT) begin errs++; $display("FAIL nominal_rise got=%0d want=%0d", r, RISE_LAT); end
    checks++; if (w != ew) begin errs++; $display("FAIL nominal_width got=%0d want=%0d", w, ew); end
    checks++; if (rc != RECC) begin errs++; $display("FAIL nominal_recover got=%0d want=%0d", rc, RECC); end
    checks++; if (trig_count !== 16'(exp_count)) begin errs++; $display("FAIL nominal_count got=%0d want=%0d", trig_count, exp_count); end
  endtask

  task automatic test_short_trig();
    int err_cyc = 0;
    int echo_seen = 0;
    pulse_trig(5);
    repeat (40) begin
      @(negedge clk);
      if (short_trig_err) err_cyc++;
      if (echo) echo_seen++;
    end
    checks++; if (err_cyc != 1) begin errs++; $display("FAIL short_err_width got=%0d want=1", err_cyc); end
    checks++; if (echo_seen != 0) begin errs++; $display("FAIL short_echo got=%0d want=0", echo_seen); end
    checks++; if (trig_count !== 16'(exp_count)) begin errs++; $display("FAIL short_count got=%0d want=%0d", trig_count, exp_count); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL short_idle busy=%b want=0", busy); end
  endtask

  task automatic test_no_target();
    int dl[4] = '{0, 450, 101, 100};
    int r, w, rc, ew;
    for (int i = 0; i < 4; i++) begin
      distance_cm = 9'(dl[i]);
      ew = model_width(dl[i]);
      model_accept();
      pulse_trig(20);
      measure(r, w, rc);
      checks++; if (w != ew) begin errs++; $display("FAIL range_width d=%0d got=%0d want=%0d", dl[i], w, ew); end
    end
  endtask

  task automatic test_ignore_busy();
    int r, w, rc, ew;
    distance_cm = 9'd5;
    ew = model_width(5);
    model_accept();
    pulse_trig(20);
    fork
      measure(r, w, rc);
      begin
        int g = 0;
        while (!echo && g < 2000) begin @(negedge clk); g++; end
        repeat (5) @(negedge clk);
        trig = 1'b1;
        distance_cm = 9'd100;
        repeat (20) @(negedge clk);
        trig = 1'b0;
      end
    join
    checks++; if (w != ew) begin errs++; $display("FAIL busy_width got=%0d want=%0d", w, ew); end
    checks++; if (trig_count !== 16'(exp_count)) begin errs++; $display("FAIL busy_count got=%0d want=%0d", trig_count, exp_count); end
    ew = model_width(100);
    model_accept();
    pulse_trig(20);
    measure(r, w, rc);
    checks++; if (w != ew) begin errs++; $display("FAIL followup_width got=%0d want=%0d", w, ew); end
  endtask

  task automatic test_reset_mid_echo();
    int g = 0;
    distance_cm = 9'd50;
    pulse_trig(20);
    while (!echo && g < 2000) begin @(negedge clk); g++; end
    checks++; if (echo !== 1'b1) begin errs++; $display("FAIL midecho_reach echo=%b want=1", echo); end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++; if (echo !== 1'b0) begin errs++; $display("FAIL midecho_echo got=%b want=0", echo); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL midecho_busy got=%b want=0", busy); end
    checks++; if (trig_count !== 16'h0) begin errs++; $display("FAIL midecho_count got=%0d want=0", trig_count); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_trig_across_reset();
    int echo_seen = 0;
    int busy_seen = 0;
    distance_cm = 9'd20;
    trig = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
    trig = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (echo) echo_seen++;
      if (busy) busy_seen++;
    end
    checks++; if (echo_seen != 0) begin errs++; $display("FAIL across_echo got=%0d want=0", echo_seen); end
    checks++; if (busy_seen != 0) begin errs++; $display("FAIL across_busy got=%0d want=0", busy_seen); end
    checks++; if (trig_count !== 16'h0) begin errs++; $display("FAIL across_count got=%0d want=0", trig_count); end
  endtask

  task automatic test_saturation();
    int r, w, rc;
    @(negedge clk);
    force dut.trig_count_q = 16'hFFFE;
    repeat (2) @(negedge clk);
    release dut.trig_count_q;
    exp_count = 65534;
    @(negedge clk);
    checks++; if (trig_count !== 16'hFFFE) begin errs++; $display("FAIL sat_preset got=%h want=fffe", trig_count); end
    for (int i = 0; i < 2; i++) begin
      distance_cm = 9'(3 + i);
      void'(model_width(3 + i));
      model_accept();
      pulse_trig(20);
      measure(r, w, rc);
      checks++; if (trig_count !== 16'(exp_count)) begin errs++; $display("FAIL sat_count%0d got=%h want=%h", i, trig_count, 16'(exp_count)); end
    end
  endtask

  task automatic test_random();
    int r, w, rc, ew, d, h;
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 511));
      h = int'($urandom_range(12, 40));
      distance_cm = 9'(d);
      ew = model_width(d);
      model_accept();
      pulse_trig(h);
      measure(r, w, rc);
      checks++; if (r != RISE_LAT) begin errs++; $display("FAIL rand_rise d=%0d got=%0d want=%0d", d, r, RISE_LAT); end
      checks++; if (w != ew) begin errs++; $display("FAIL rand_width d=%0d got=%0d want=%0d", d, w, ew); end
      checks++; if (rc != RECC) begin errs++; $display("FAIL rand_recover d=%0d got=%0d want=%0d", d, rc, RECC); end
      checks++; if (trig_count !== 16'(exp_count)) begin errs++; $display("FAIL rand_count got=%0d want=%0d", trig_count, exp_count); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_trig();
    test_no_target();
    test_ignore_busy();
    test_random();
    test_reset_mid_echo();
    test_trig_across_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
